// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI USB host-controller responder.
// Holds the transaction state enum, register map constants and command bit fields.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    localparam int NUM_REGS      = 32;
    localparam int HIRQ_ADDR_DEF = 25;
    localparam int HIEN_ADDR_DEF = 26;

    // command byte layout: addr[7:3], dir[1] (1 = write), bit 0 ignored
    localparam int ADDR_HI = 7;
    localparam int ADDR_LO = 3;
    localparam int DIR_BIT = 1;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, plus edge pulses.
// Ports: clk, rst_n, pin (async in); level (synced), rise/fall (1-Clk pulses).
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] stg;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg  <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            stg  <= {stg[STAGES-2:0], pin};
            prev <= stg[STAGES-1];
        end
    end

    assign level = stg[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_usb_responder.sv
// SPI mode-0 slave emulating the USB host-controller register file (32x8).
// Ports: Clk, Reset_n; spi_sclk/ss_n/mosi in, spi_miso/spi_miso_oe out;
// fab_we/fab_addr/fab_data fabric writes (HIRQ bits OR-set); irq_n out.
// Option: SPI_RESP_AUTOINC_EN makes the address step after each data byte.
module spi_usb_responder
    import spi_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HIRQ_ADDR   = HIRQ_ADDR_DEF,
    parameter int HIEN_ADDR   = HIEN_ADDR_DEF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       fab_we,
    input  logic [4:0] fab_addr,
    input  logic [7:0] fab_data,
    output logic       irq_n
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (Clk),
        .rst_n (Reset_n),
        .pin   (spi_sclk),
        .level (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // select idles high so reset does not look like a falling edge
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk   (Clk),
        .rst_n (Reset_n),
        .pin   (spi_ss_n),
        .level (ss_s),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (Clk),
        .rst_n (Reset_n),
        .pin   (spi_mosi),
        .level (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, ss_s, mosi_rise, mosi_fall};

    state_t     state, state_nxt;
    logic [7:0] regs     [NUM_REGS];
    logic [7:0] regs_nxt [NUM_REGS];
    logic [7:0] tx_sh, rx_sh;
    logic [2:0] bit_cnt;
    logic [4:0] addr, next_addr;
    logic       dir;

    logic [7:0] byte_in;
    logic       bit_evt, byte_done, spi_wr;

    assign byte_in   = {rx_sh[6:0], mosi_s};
    // a select rise in the same cycle cancels the clock edge
    assign bit_evt   = sclk_rise && (state != IDLE) && !ss_rise;
    assign byte_done = bit_evt && (bit_cnt == 3'd7);
    assign spi_wr    = byte_done && (state == DATA) && dir;

`ifdef SPI_RESP_AUTOINC_EN
    assign next_addr = addr + 5'd1;
`else
    assign next_addr = addr;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ss_rise)
            state_nxt = IDLE;
        else if (ss_fall)
            state_nxt = CMD;
        else if (byte_done && state == CMD)
            state_nxt = DATA;
    end

    // SPI write beats fabric write; on HIRQ a fabric set beats an SPI clear
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_nxt[i] = regs[i];
            if (i == HIRQ_ADDR) begin
                if (spi_wr && addr == 5'(i))
                    regs_nxt[i] = regs_nxt[i] & ~byte_in;
                if (fab_we && fab_addr == 5'(i))
                    regs_nxt[i] = regs_nxt[i] | fab_data;
            end else if (spi_wr && addr == 5'(i)) begin
                regs_nxt[i] = byte_in;
            end else if (fab_we && fab_addr == 5'(i)) begin
                regs_nxt[i] = fab_data;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs        <= '{default: '0};
            tx_sh       <= '0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            addr        <= '0;
            dir         <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            irq_n       <= 1'b1;
        end else begin
            regs  <= regs_nxt;
            irq_n <= ~|(regs[HIRQ_ADDR] & regs[HIEN_ADDR]);
            if (ss_rise) begin
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
            end else if (ss_fall) begin
                spi_miso_oe <= 1'b1;
                spi_miso    <= regs[HIRQ_ADDR][7];
                tx_sh       <= {regs[HIRQ_ADDR][6:0], 1'b0};
                rx_sh       <= '0;
                bit_cnt     <= '0;
            end else if (bit_evt) begin
                rx_sh   <= byte_in;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == CMD) begin
                        addr  <= byte_in[ADDR_HI:ADDR_LO];
                        dir   <= byte_in[DIR_BIT];
                        tx_sh <= byte_in[DIR_BIT] ? 8'h00
                               : regs[byte_in[ADDR_HI:ADDR_LO]];
                    end else begin
                        addr  <= next_addr;
                        tx_sh <= dir ? 8'h00 : regs_nxt[next_addr];
                    end
                end
            end else if (sclk_fall && state != IDLE) begin
                spi_miso <= tx_sh[7];
                tx_sh    <= {tx_sh[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_usb_responder.sv
// Directed self-checking bench for spi_usb_responder.
// Drives a mode-0 SPI master and fabric writes; checks with immediate asserts.
module tb_spi_usb_responder;

    localparam int HALF = 8;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       spi_sclk, spi_ss_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic       fab_we;
    logic [4:0] fab_addr;
    logic [7:0] fab_data;
    logic       irq_n;

    int checks = 0;
    int errors = 0;

    spi_usb_responder dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .spi_sclk    (spi_sclk),
        .spi_ss_n    (spi_ss_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .fab_we      (fab_we),
        .fab_addr    (fab_addr),
        .fab_data    (fab_data),
        .irq_n       (irq_n)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge Clk);
    endtask

    task automatic spi_begin();
        repeat (4) @(negedge Clk);
        spi_ss_n = 1'b0;
        half_period();
    endtask

    task automatic spi_end();
        half_period();
        spi_ss_n = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    // nbits MSB-first bits; inj fires a fabric write to reg 4 in the
    // same Clk the DUT acts on the 8th rising SCLK edge
    task automatic xfer(input logic [7:0] tx, input int nbits,
                        input bit inj, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            half_period();
            rx[i]    = spi_miso;
            spi_sclk = 1'b1;
            if (inj && i == 0) begin
                @(negedge Clk);
                @(negedge Clk);
                fab_we   = 1'b1;
                fab_addr = 5'd4;
                fab_data = 8'h55;
                @(negedge Clk);
                fab_we   = 1'b0;
                repeat (HALF - 3) @(negedge Clk);
            end else begin
                half_period();
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic fab_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge Clk);
        fab_we   = 1'b1;
        fab_addr = a;
        fab_data = d;
        @(negedge Clk);
        fab_we   = 1'b0;
    endtask

    task automatic spi_wr(input logic [7:0] cmd, input logic [7:0] d);
        logic [7:0] r;
        spi_begin();
        xfer(cmd, 8, 1'b0, r);
        xfer(d, 8, 1'b0, r);
        spi_end();
    endtask

    task automatic spi_rd(input logic [7:0] cmd, output logic [7:0] d);
        logic [7:0] r;
        spi_begin();
        xfer(cmd, 8, 1'b0, r);
        xfer(8'h00, 8, 1'b0, d);
        spi_end();
    endtask

    initial begin
        logic [7:0] r0, r1;

        Reset_n  = 1'b0;
        spi_sclk = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        fab_we   = 1'b0;
        fab_addr = '0;
        fab_data = '0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_oe", {7'd0, spi_miso_oe}, 8'h00);
        chk("rst_miso", {7'd0, spi_miso}, 8'h00);
        chk("rst_irq_n", {7'd0, irq_n}, 8'h01);

        // status read: byte0 shifts HIRQ, byte1 returns reg25
        fab_write(5'd25, 8'h04);
        spi_begin();
        xfer(8'hC8, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        spi_end();
        chk("rd_status_b0", r0, 8'h04);
        chk("rd_status_b1", r1, 8'h04);
        chk("irq_masked", {7'd0, irq_n}, 8'h01);

        // enable HIRQ bit 2 -> interrupt asserted
        spi_begin();
        xfer(8'hD2, 8, 1'b0, r0);
        xfer(8'h04, 8, 1'b0, r1);
        spi_end();
        chk("wr_hien_b0", r0, 8'h04);
        chk("irq_assert", {7'd0, irq_n}, 8'h00);
        spi_rd(8'hD0, r0);
        chk("rd_hien", r0, 8'h04);

        // write-1-to-clear HIRQ
        spi_wr(8'hCA, 8'h04);
        chk("irq_clear", {7'd0, irq_n}, 8'h01);
        spi_rd(8'hC8, r0);
        chk("rd_hirq_cleared", r0, 8'h00);

        // aborted data byte must not write
        spi_wr(8'h1A, 8'hA5);
        spi_begin();
        xfer(8'h1A, 8, 1'b0, r0);
        xfer(8'h00, 5, 1'b0, r0);
        chk("oe_mid_xfer", {7'd0, spi_miso_oe}, 8'h01);
        spi_ss_n = 1'b1;
        repeat (4) @(negedge Clk);
        chk("oe_after_abort", {7'd0, spi_miso_oe}, 8'h00);
        spi_rd(8'h18, r0);
        chk("rd_reg3_kept", r0, 8'hA5);

        // SCLK toggles with select high are ignored
        spi_mosi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            half_period();
            spi_sclk = 1'b1;
            half_period();
            spi_sclk = 1'b0;
        end
        chk("oe_idle_sclk", {7'd0, spi_miso_oe}, 8'h00);
        spi_rd(8'h18, r0);
        chk("rd_reg3_idle", r0, 8'hA5);

        // multi-byte write from reg 30
        spi_begin();
        xfer(8'hF2, 8, 1'b0, r0);
        xfer(8'h11, 8, 1'b0, r0);
        xfer(8'h22, 8, 1'b0, r0);
        xfer(8'h33, 8, 1'b0, r0);
        spi_end();
        spi_rd(8'hF0, r0);
`ifdef SPI_RESP_AUTOINC_EN
        chk("burst_r30", r0, 8'h11);
        spi_rd(8'hF8, r0);
        chk("burst_r31", r0, 8'h22);
        spi_rd(8'h00, r0);
        chk("burst_r0", r0, 8'h33);
`else
        chk("burst_r30", r0, 8'h33);
        spi_rd(8'hF8, r0);
        chk("burst_r31", r0, 8'h00);
        spi_rd(8'h00, r0);
        chk("burst_r0", r0, 8'h00);
`endif

        // same-cycle fabric and SPI writes to reg 4
        spi_begin();
        xfer(8'h22, 8, 1'b0, r0);
        xfer(8'hAA, 8, 1'b1, r0);
        spi_end();
        spi_rd(8'h20, r0);
        chk("collide_reg4", r0, 8'hAA);

        // plain fabric write, then SPI readback
        fab_write(5'd7, 8'h3C);
        spi_rd(8'h38, r0);
        chk("fab_reg7", r0, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
